// File: rtl/td4p_core.sv
// td4p_core: parametrised TD4-compatible CPU core with writable program memory.
// Latency: single-cycle execute; fetch (opcode) and alu_data are combinational from pc.
// Backpressure: run=0 (or halted) holds all architectural state; program writes still land.
//
// Optional feature macro: TD4P_HALT_EN (op 1000 becomes HLT and a 'halted' output appears).
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   run               1 = retire one instruction this cycle
//   in_port           switch input sampled by IN A / IN B
//   prog_we/addr/wdata program memory write port ({op[3:0], imm})
//   pc_out, opcode    current PC and the instruction word stored there
//   out_port          registered output port
//   alu_data          combinational ALU result for the current instruction
//   carry, instret    carry flag, retired-instruction counter
//   halted            (TD4P_HALT_EN only) core stopped on HLT until reset
module td4p_core #(
    parameter int DATA_W = 4,
    parameter int PC_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    input  logic [DATA_W-1:0]   in_port,
    input  logic                prog_we,
    input  logic [PC_W-1:0]     prog_addr,
    input  logic [4+DATA_W-1:0] prog_wdata,
    output logic [PC_W-1:0]     pc_out,
    output logic [4+DATA_W-1:0] opcode,
    output logic [DATA_W-1:0]   out_port,
    output logic [DATA_W-1:0]   alu_data,
    output logic                carry,
    output logic [CNT_W-1:0]    instret
`ifdef TD4P_HALT_EN
    ,
    output logic                halted
`endif
);

    localparam int IW = 4 + DATA_W;

    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_A  = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_B  = 4'b0111;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_OUT_I  = 4'b1011;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;
`ifdef TD4P_HALT_EN
    localparam logic [3:0] OP_HLT    = 4'b1000;
`endif

    // Program memory: never reset, written on any edge with prog_we.
    logic [IW-1:0] mem_q [2**PC_W];

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              carry_q, carry_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
`ifdef TD4P_HALT_EN
    logic              halt_q, halt_d;
`endif

    logic [3:0]        op;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] opnd;
    logic [DATA_W-1:0] addend;
    logic [DATA_W:0]   sum;
    logic              exec;

    always_ff @(posedge clock) begin
        if (prog_we) begin
            mem_q[prog_addr] <= prog_wdata;
        end
    end

    // Fetch reads the pre-edge word, so a same-edge write to mem[pc] only
    // affects the next visit to that address.
    assign opcode = mem_q[pc_q];
    assign op     = opcode[IW-1:DATA_W];
    assign imm    = opcode[DATA_W-1:0];

`ifdef TD4P_HALT_EN
    assign exec = run & ~halt_q;
`else
    assign exec = run;
`endif

    // ALU source mux: register/port + imm for ADD and immediate forms,
    // register/port + 0 for the register-move forms.
    always_comb begin
        opnd   = '0;
        addend = imm;
        case (op)
            OP_ADD_A:           opnd = a_q;
            OP_ADD_B:           opnd = b_q;
            OP_MOV_AB, OP_OUT_B: begin opnd = b_q;     addend = '0; end
            OP_MOV_BA:          begin opnd = a_q;     addend = '0; end
            OP_IN_A, OP_IN_B:   begin opnd = in_port; addend = '0; end
            default: ;
        endcase
    end

    assign sum      = {1'b0, opnd} + {1'b0, addend};
    assign alu_data = sum[DATA_W-1:0];

    always_comb begin
        pc_d      = pc_q;
        a_d       = a_q;
        b_d       = b_q;
        out_d     = out_q;
        carry_d   = carry_q;
        instret_d = instret_q;
`ifdef TD4P_HALT_EN
        halt_d    = halt_q;
`endif
        if (exec) begin
            pc_d      = pc_q + PC_W'(1);
            carry_d   = 1'b0;
            instret_d = instret_q + CNT_W'(1);
            case (op)
                OP_ADD_A:                     begin a_d = alu_data; carry_d = sum[DATA_W]; end
                OP_ADD_B:                     begin b_d = alu_data; carry_d = sum[DATA_W]; end
                OP_MOV_A, OP_MOV_AB, OP_IN_A: a_d   = alu_data;
                OP_MOV_B, OP_MOV_BA, OP_IN_B: b_d   = alu_data;
                OP_OUT_B, OP_OUT_I:           out_d = alu_data;
                OP_JMP:                       pc_d  = imm[PC_W-1:0];
                // Tests the flag as it was before this instruction.
                OP_JNC: if (!carry_q)         pc_d  = imm[PC_W-1:0];
`ifdef TD4P_HALT_EN
                OP_HLT:                       begin pc_d = pc_q; halt_d = 1'b1; end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            out_q     <= '0;
            carry_q   <= 1'b0;
            instret_q <= '0;
`ifdef TD4P_HALT_EN
            halt_q    <= 1'b0;
`endif
        end else begin
            pc_q      <= pc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            out_q     <= out_d;
            carry_q   <= carry_d;
            instret_q <= instret_d;
`ifdef TD4P_HALT_EN
            halt_q    <= halt_d;
`endif
        end
    end

    assign pc_out   = pc_q;
    assign out_port = out_q;
    assign carry    = carry_q;
    assign instret  = instret_q;
`ifdef TD4P_HALT_EN
    assign halted   = halt_q;
`endif

endmodule

// File: tb/tb_td4p_core.sv
// tb_td4p_core: self-checking bench for td4p_core (default 4/4 build plus an 8/5 build).
// Latency: one vector per clock; post-edge state compared #1 after the rising edge.
// Backpressure: none; run is driven directly from the vector table.
module tb_td4p_core;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Default-parameter DUT
    logic        reset, run, prog_we, carry;
    logic [3:0]  in_port, prog_addr, pc_out, out_port, alu_data;
    logic [7:0]  prog_wdata, opcode;
    logic [15:0] instret;
    // DATA_W=8, PC_W=5 DUT
    logic        w_reset, w_run, w_prog_we, w_carry;
    logic [7:0]  w_in_port, w_out_port, w_alu_data;
    logic [4:0]  w_prog_addr, w_pc_out;
    logic [11:0] w_prog_wdata, w_opcode;
    logic [15:0] w_instret;
`ifdef TD4P_HALT_EN
    logic        halted, w_halted;
`endif

    td4p_core u_dut (
        .clock(clock), .reset(reset), .run(run), .in_port(in_port),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .pc_out(pc_out), .opcode(opcode), .out_port(out_port),
        .alu_data(alu_data), .carry(carry), .instret(instret)
`ifdef TD4P_HALT_EN
        , .halted(halted)
`endif
    );

    td4p_core #(.DATA_W(8), .PC_W(5), .CNT_W(16)) u_dut8 (
        .clock(clock), .reset(w_reset), .run(w_run), .in_port(w_in_port),
        .prog_we(w_prog_we), .prog_addr(w_prog_addr), .prog_wdata(w_prog_wdata),
        .pc_out(w_pc_out), .opcode(w_opcode), .out_port(w_out_port),
        .alu_data(w_alu_data), .carry(w_carry), .instret(w_instret)
`ifdef TD4P_HALT_EN
        , .halted(w_halted)
`endif
    );

    typedef struct {
        logic        rst;
        logic        run;
        logic [3:0]  inp;
        logic        we;
        logic [3:0]  wa;
        logic [7:0]  wd;
        logic        chk_alu;
        logic [3:0]  e_alu;
        logic [3:0]  e_pc;
        logic [3:0]  e_out;
        logic        e_c;
        logic [15:0] e_ins;
    } vec_t;

    typedef struct {
        logic [3:0]  pc;
        logic [3:0]  out;
        logic        c;
        logic [15:0] ins;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic v(input logic rst, input logic rn, input logic [3:0] inp,
                     input logic we, input logic [3:0] wa, input logic [7:0] wd,
                     input logic ca, input logic [3:0] ealu, input logic [3:0] epc,
                     input logic [3:0] eout, input logic ec, input logic [15:0] eins);
        vec_t r;
        r.rst = rst; r.run = rn; r.inp = inp; r.we = we; r.wa = wa; r.wd = wd;
        r.chk_alu = ca; r.e_alu = ealu; r.e_pc = epc; r.e_out = eout;
        r.e_c = ec; r.e_ins = eins;
        tbl.push_back(r);
    endtask

    // Program load under reset: every such edge must also show the reset state.
    task automatic ld(input logic [3:0] wa, input logic [7:0] wd);
        v(1'b1, 1'b0, 4'h0, 1'b1, wa, wd, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0);
    endtask

    task automatic apply(input vec_t r);
        exp_t e, got;
        @(negedge clock);
        reset = r.rst; run = r.run; in_port = r.inp;
        prog_we = r.we; prog_addr = r.wa; prog_wdata = r.wd;
        #1;
        if (r.chk_alu) chk("alu_data", {60'h0, alu_data}, {60'h0, r.e_alu});
        e.pc = r.e_pc; e.out = r.e_out; e.c = r.e_c; e.ins = r.e_ins;
        sb.push_back(e);
        @(posedge clock);
        #1;
        got = sb.pop_front();
        chk("pc_out",   {60'h0, pc_out},   {60'h0, got.pc});
        chk("out_port", {60'h0, out_port}, {60'h0, got.out});
        chk("carry",    {63'h0, carry},    {63'h0, got.c});
        chk("instret",  {48'h0, instret},  {48'h0, got.ins});
`ifdef TD4P_HALT_EN
        chk("halted",   {63'h0, halted},   64'h0);
`endif
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) apply(tbl[i]);
        tbl.delete();
    endtask

    task automatic step8(input logic rst, input logic rn, input logic we,
                         input logic [4:0] wa, input logic [11:0] wd);
        @(negedge clock);
        w_reset = rst; w_run = rn; w_prog_we = we; w_prog_addr = wa; w_prog_wdata = wd;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; in_port = '0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        w_reset = 1'b1; w_run = 1'b0; w_in_port = '0; w_prog_we = 1'b0;
        w_prog_addr = '0; w_prog_wdata = '0;

        // 16 NOPs: pc walks 0..15 and wraps to 0 on edge 16, carry stays 0.
        for (int i = 0; i < 16; i++) ld(4'(i), 8'hC0);
        for (int i = 0; i < 16; i++)
            v(1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 4'(i + 1), 4'h0, 1'b0, 16'(i + 1));
        run_tbl();

        // MOV A,3 / ADD A,14 / JNC 0 (not taken) / OUT 5
        ld(4'd0, 8'h33); ld(4'd1, 8'h0E); ld(4'd2, 8'hE0); ld(4'd3, 8'hB5);
        v(0, 1, 4'h0, 0, 4'h0, 8'h00, 1, 4'h3, 4'd1, 4'h0, 0, 16'd1);
        v(0, 1, 4'h0, 0, 4'h0, 8'h00, 1, 4'h1, 4'd2, 4'h0, 1, 16'd2);
        v(0, 1, 4'h0, 0, 4'h0, 8'h00, 1, 4'h0, 4'd3, 4'h0, 0, 16'd3);
        v(0, 1, 4'h0, 0, 4'h0, 8'h00, 1, 4'h5, 4'd4, 4'h5, 0, 16'd4);
        run_tbl();

        // IN B / OUT B with two stalled cycles; in_port changes during the stall.
        ld(4'd0, 8'h60); ld(4'd1, 8'h90); ld(4'd2, 8'hC0);
        v(0, 1, 4'h9, 0, 4'h0, 8'h00, 1, 4'h9, 4'd1, 4'h0, 0, 16'd1);
        v(0, 0, 4'h3, 0, 4'h0, 8'h00, 1, 4'h9, 4'd1, 4'h0, 0, 16'd1);
        v(0, 0, 4'h3, 0, 4'h0, 8'h00, 1, 4'h9, 4'd1, 4'h0, 0, 16'd1);
        v(0, 1, 4'h3, 0, 4'h0, 8'h00, 1, 4'h9, 4'd2, 4'h9, 0, 16'd2);
        run_tbl();

        // Overwrite mem[pc] with JMP 7 while it executes ADD A,1.
        ld(4'd0, 8'h01); ld(4'd1, 8'hF0); ld(4'd7, 8'hC0);
        v(0, 1, 4'h0, 1, 4'h0, 8'hF7, 1, 4'h1, 4'd1, 4'h0, 0, 16'd1);
        v(0, 1, 4'h0, 0, 4'h0, 8'h00, 1, 4'h0, 4'd0, 4'h0, 0, 16'd2);
        run_tbl();
        chk("opcode_rewritten", {56'h0, opcode}, 64'hF7);
        v(0, 1, 4'h0, 0, 4'h0, 8'h00, 1, 4'h7, 4'd7, 4'h0, 0, 16'd3);
        run_tbl();

        // Reset mid-program after carry set (reset wins over run), then identical rerun.
        ld(4'd0, 8'h75); ld(4'd1, 8'h90); ld(4'd2, 8'h3F); ld(4'd3, 8'h01); ld(4'd4, 8'hC0);
        for (int pass = 0; pass < 2; pass++) begin
            v(0, 1, 4'h0, 0, 4'h0, 8'h00, 1, 4'h5, 4'd1, 4'h0, 0, 16'd1);
            v(0, 1, 4'h0, 0, 4'h0, 8'h00, 1, 4'h5, 4'd2, 4'h5, 0, 16'd2);
            v(0, 1, 4'h0, 0, 4'h0, 8'h00, 1, 4'hF, 4'd3, 4'h5, 0, 16'd3);
            v(0, 1, 4'h0, 0, 4'h0, 8'h00, 1, 4'h0, 4'd4, 4'h5, 1, 16'd4);
            if (pass == 0)
                v(1, 1, 4'h0, 0, 4'h0, 8'h00, 0, 4'h0, 4'd0, 4'h0, 0, 16'd0);
        end
        run_tbl();

        // JNC taken when carry is clear.
        ld(4'd0, 8'hE5);
        v(0, 1, 4'h0, 0, 4'h0, 8'h00, 1, 4'h5, 4'd5, 4'h0, 0, 16'd1);
        run_tbl();
        @(negedge clock);
        run = 1'b0;

        // Wide build: MOV A,1 / ADD A,0xFF / JMP 0x3F / (mem31) op 1000
        step8(1, 0, 1, 5'd0,  12'h301);
        step8(1, 0, 1, 5'd1,  12'h0FF);
        step8(1, 0, 1, 5'd2,  12'hF3F);
        step8(1, 0, 1, 5'd31, 12'h800);
        chk("w8_reset_pc",      {59'h0, w_pc_out},  64'h0);
        chk("w8_reset_instret", {48'h0, w_instret}, 64'h0);
        step8(0, 1, 0, 5'd0, 12'h000);
        chk("w8_pc_after_mov",  {59'h0, w_pc_out},   64'h1);
        chk("w8_alu_add_ff",    {56'h0, w_alu_data}, 64'h0);
        step8(0, 1, 0, 5'd0, 12'h000);
        chk("w8_carry_add_ff",  {63'h0, w_carry},    64'h1);
        chk("w8_pc_after_add",  {59'h0, w_pc_out},   64'h2);
        step8(0, 1, 0, 5'd0, 12'h000);
        chk("w8_jmp_trunc_pc",  {59'h0, w_pc_out},   64'h1F);
        chk("w8_carry_after_jmp", {63'h0, w_carry},  64'h0);
        chk("w8_opcode_31",     {52'h0, w_opcode},   64'h800);
        step8(0, 1, 0, 5'd0, 12'h000);
`ifdef TD4P_HALT_EN
        chk("w8_hlt_pc",        {59'h0, w_pc_out},   64'h1F);
        chk("w8_hlt_instret",   {48'h0, w_instret},  64'h4);
        chk("w8_halted",        {63'h0, w_halted},   64'h1);
        step8(0, 1, 0, 5'd0, 12'h000);
        chk("w8_halt_pc_hold",  {59'h0, w_pc_out},   64'h1F);
        chk("w8_halt_ins_hold", {48'h0, w_instret},  64'h4);
`else
        chk("w8_nop_pc_wrap",   {59'h0, w_pc_out},   64'h0);
        chk("w8_nop_instret",   {48'h0, w_instret},  64'h4);
        chk("w8_nop_carry",     {63'h0, w_carry},    64'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
